// File: rtl/endpoint_cache_arbiter.sv
// Purpose : round-robin N-port arbiter sharing one endpoint cache port (TX or RX cache) between
//           the host bus and packet FSMs. It adds a burst cap, bounds checking and per-port
//           write protection.
// Latency : a grant takes 1 cycle (an IDLE cycle with no cache access). After that the owner's
//           request is forwarded combinationally to the cache.
// Backpressure: a port is stalled while it is active and is not the owner. The owner sees cache_stall.
// Ports   : clk, n_rst (async active-low)
//           req_ren/req_wen/req_addr/req_wdata/req_strobe -> per-port requests
//           req_rdata/req_error/req_stall                 <- per-port responses
//           cache_ren/cache_wen/cache_addr/cache_wdata/cache_strobe -> cache request
//           cache_rdata/cache_error/cache_stall                     <- cache response
//           owner/owner_valid                             -> current grant
module endpoint_cache_arbiter #(
  parameter int                   NUM_PORTS       = 3,
  parameter int                   CACHE_NUM_WORDS = 128,
  parameter int                   MAX_BURST       = 4,
  parameter logic [NUM_PORTS-1:0] RO_MASK         = '0,
  localparam int                  ADDR_WIDTH      = $clog2(4*CACHE_NUM_WORDS),
  localparam int                  OWNER_WIDTH     = $clog2(NUM_PORTS)
) (
  input  logic                                  clk,
  input  logic                                  n_rst,
  input  logic [NUM_PORTS-1:0]                  req_ren,
  input  logic [NUM_PORTS-1:0]                  req_wen,
  input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS-1:0][31:0]            req_wdata,
  input  logic [NUM_PORTS-1:0][3:0]             req_strobe,
  output logic [NUM_PORTS-1:0][31:0]            req_rdata,
  output logic [NUM_PORTS-1:0]                  req_error,
  output logic [NUM_PORTS-1:0]                  req_stall,
  output logic                                  cache_ren,
  output logic                                  cache_wen,
  output logic [ADDR_WIDTH-1:0]                 cache_addr,
  output logic [31:0]                           cache_wdata,
  output logic [3:0]                            cache_strobe,
  input  logic [31:0]                           cache_rdata,
  input  logic                                  cache_error,
  input  logic                                  cache_stall,
  output logic [OWNER_WIDTH-1:0]                owner,
  output logic                                  owner_valid
);

  localparam int BURST_WIDTH = $clog2(MAX_BURST + 1);
  // One bit wider than the address so that a power-of-two cache depth still has a valid limit.
  // In that case no address can exceed the limit.
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(4*CACHE_NUM_WORDS);
  localparam logic [31:0]         RDATA_IDLE = 32'hBAD1BAD1;

  typedef enum logic {IDLE, OWNED} state_t;

  state_t                  state, state_nxt;
  logic [OWNER_WIDTH-1:0]  owner_nxt, last_owner, last_owner_nxt, pick;
  logic [BURST_WIDTH-1:0]  burst_cnt, burst_cnt_nxt;
  logic [NUM_PORTS-1:0]    active, others;
  logic                    pick_vld, own_act, illegal, complete, burst_done;

  assign active      = req_ren | req_wen;
  assign owner_valid = (state == OWNED);

  // Round-robin scan starts at last_owner+1. The loop runs from the far end backwards, so the
  // nearest active port is the last one assigned and wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (active[(int'(last_owner) + k) % NUM_PORTS]) begin
        pick     = OWNER_WIDTH'((int'(last_owner) + k) % NUM_PORTS);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    own_act    = active[owner];
    illegal    = own_act && (({1'b0, req_addr[owner]} >= ADDR_LIMIT) ||
                             (req_ren[owner] && req_wen[owner]) ||
                             (req_wen[owner] && RO_MASK[owner]));
    complete   = (state == OWNED) && own_act && (illegal || !cache_stall);
    burst_done = (int'(burst_cnt) + 1 >= MAX_BURST);
    others        = active;
    others[owner] = 1'b0;

    req_rdata    = {NUM_PORTS{RDATA_IDLE}};
    req_error    = '0;
    req_stall    = active;
    cache_ren    = 1'b0;
    cache_wen    = 1'b0;
    cache_addr   = '0;
    cache_wdata  = '0;
    cache_strobe = '0;

    if (state == OWNED && own_act) begin
      if (illegal) begin
        // The illegal access is rejected without touching the cache. It still retires in one cycle.
        req_error[owner] = 1'b1;
        req_stall[owner] = 1'b0;
      end else begin
        cache_ren        = req_ren[owner];
        cache_wen        = req_wen[owner];
        cache_addr       = req_addr[owner];
        cache_wdata      = req_wdata[owner];
        cache_strobe     = req_strobe[owner];
        req_rdata[owner] = cache_rdata;
        req_error[owner] = cache_error;
        req_stall[owner] = cache_stall;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    last_owner_nxt = last_owner;
    burst_cnt_nxt  = burst_cnt;
    case (state)
      IDLE: begin
        if (pick_vld) begin
          state_nxt      = OWNED;
          owner_nxt      = pick;
          last_owner_nxt = pick;
          burst_cnt_nxt  = '0;
        end
      end
      OWNED: begin
        if (!own_act) begin
          // Owner dropped its request, possibly mid-stall. The access is abandoned.
          state_nxt = IDLE;
        end else if (complete) begin
          if (burst_done) begin
            // The owner yields only when someone is waiting. Otherwise the counter stays at
            // the cap, so the owner yields on its next completion once a waiter appears.
            if (|others) state_nxt = IDLE;
          end else begin
            burst_cnt_nxt = burst_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      owner      <= '0;
      last_owner <= OWNER_WIDTH'(NUM_PORTS - 1);
      burst_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      last_owner <= last_owner_nxt;
      burst_cnt  <= burst_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_endpoint_cache_arbiter.sv
// Purpose : self-checking bench for endpoint_cache_arbiter. It uses directed scenarios plus a
//           randomized run checked against a behavioural reference model.
// Latency : the bench drives inputs 1 time unit after a rising edge and samples on the falling edge.
// Backpressure: a small cache model with a controllable stall and a byte-strobed memory.
module tb_endpoint_cache_arbiter;

  localparam int          NP  = 3;
  localparam int          NW  = 96;   // 384-byte cache, so that 9-bit addresses can fall out of range
  localparam int          MB  = 4;
  localparam logic [2:0]  RO  = 3'b010;
  localparam logic [31:0] BAD = 32'hBAD1BAD1;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [2:0]        ren, wen;
  logic [2:0][8:0]   addr;
  logic [2:0][31:0]  wdata;
  logic [2:0][3:0]   strobe;
  logic [2:0][31:0]  rdata;
  logic [2:0]        error, stall;
  logic              cache_ren, cache_wen, cstall, cerr;
  logic [8:0]        cache_addr;
  logic [31:0]       cache_wdata, cache_rdata;
  logic [3:0]        cache_strobe;
  logic [1:0]        owner;
  logic              owner_valid;

  int tests = 0;
  int fails = 0;

  // Reference model state: whether a port owns the cache, which port owns it,
  // the last port granted, and the number of completions in the current tenure.
  bit m_owned;
  int m_owner, m_last, m_cnt;

  logic [31:0] mem [0:NW-1];

  always #5 clk = ~clk;

  endpoint_cache_arbiter #(
    .NUM_PORTS(NP), .CACHE_NUM_WORDS(NW), .MAX_BURST(MB), .RO_MASK(RO)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .req_ren(ren), .req_wen(wen), .req_addr(addr), .req_wdata(wdata), .req_strobe(strobe),
    .req_rdata(rdata), .req_error(error), .req_stall(stall),
    .cache_ren(cache_ren), .cache_wen(cache_wen), .cache_addr(cache_addr),
    .cache_wdata(cache_wdata), .cache_strobe(cache_strobe),
    .cache_rdata(cache_rdata), .cache_error(cerr), .cache_stall(cstall),
    .owner(owner), .owner_valid(owner_valid)
  );

  // Zero-wait cache model. Word i powers up as {C0DE, i}.
  always_comb cache_rdata = (cache_ren && cache_addr[8:2] < NW) ? mem[cache_addr[8:2]] : 32'h0;

  always @(posedge clk) begin
    if (!n_rst) begin
      for (int i = 0; i < NW; i++) mem[i] <= {16'hC0DE, 16'(i)};
    end else if (cache_wen && !cstall && cache_addr[8:2] < NW) begin
      for (int b = 0; b < 4; b++)
        if (cache_strobe[b]) mem[cache_addr[8:2]][8*b +: 8] <= cache_wdata[8*b +: 8];
    end
  end

  task automatic do_reset();
    n_rst = 1'b0; ren = '0; wen = '0; addr = '0; wdata = '0; strobe = '0;
    cstall = 1'b0; cerr = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    m_owned = 0; m_owner = 0; m_last = NP - 1; m_cnt = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    @(posedge clk); #1;
    n_rst = 1'b0; ren = 3'b101; wen = 3'b010; cstall = 1'b1; addr[0] = 9'h044;
    #2;
    tests++; if (owner_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %b want 0", owner_valid); end
    tests++; if (owner !== 2'd0) begin fails++; $display("FAIL rst_owner got %0d want 0", owner); end
    tests++; if ({cache_ren, cache_wen} !== 2'b00) begin fails++; $display("FAIL rst_cache_en got %b want 00", {cache_ren, cache_wen}); end
    tests++; if ({cache_addr, cache_wdata, cache_strobe} !== '0) begin fails++; $display("FAIL rst_cache_bus got %h want 0", {cache_addr, cache_wdata, cache_strobe}); end
    tests++; if (stall !== 3'b111) begin fails++; $display("FAIL rst_stall got %b want 111", stall); end
    tests++; if (error !== 3'b000) begin fails++; $display("FAIL rst_error got %b want 000", error); end
    tests++; if (rdata !== {3{BAD}}) begin fails++; $display("FAIL rst_rdata got %h want %h", rdata, {3{BAD}}); end
    ren = 3'b001; wen = 3'b000; #1;
    tests++; if (stall !== 3'b001) begin fails++; $display("FAIL rst_stall2 got %b want 001", stall); end
  endtask

  task automatic test_first_read();
    do_reset();
    ren = 3'b001; addr[0] = 9'h010;
    @(negedge clk);
    tests++; if (stall[0] !== 1'b1) begin fails++; $display("FAIL first_c0_stall got %b want 1", stall[0]); end
    tests++; if (cache_ren !== 1'b0) begin fails++; $display("FAIL first_c0_ren got %b want 0", cache_ren); end
    tick(); @(negedge clk);
    tests++; if (cache_ren !== 1'b1) begin fails++; $display("FAIL first_c1_ren got %b want 1", cache_ren); end
    tests++; if (cache_addr !== 9'h010) begin fails++; $display("FAIL first_c1_addr got %h want 010", cache_addr); end
    tests++; if (rdata[0] !== 32'hC0DE0004) begin fails++; $display("FAIL first_c1_rdata got %h want C0DE0004", rdata[0]); end
    tests++; if (stall[0] !== 1'b0) begin fails++; $display("FAIL first_c1_stall got %b want 0", stall[0]); end
    tests++; if ({owner_valid, owner} !== 3'b100) begin fails++; $display("FAIL first_c1_owner got %b want 100", {owner_valid, owner}); end
    tick();
  endtask

  // Continuous reads on all ports. Each tenure is five cycles: one IDLE grant cycle, then 4 completions.
  task automatic test_rotation();
    do_reset();
    ren = 3'b111; addr[0] = 9'h000; addr[1] = 9'h040; addr[2] = 9'h080;
    for (int c = 0; c < 20; c++) begin
      bit ev;
      int eo;
      @(negedge clk);
      ev = (c % 5) != 0;
      eo = (c / 5) % 3;
      tests++; if (owner_valid !== ev) begin fails++; $display("FAIL rot_valid c%0d got %b want %b", c, owner_valid, ev); end
      tests++; if (cache_ren !== ev) begin fails++; $display("FAIL rot_ren c%0d got %b want %b", c, cache_ren, ev); end
      if (ev) begin
        tests++; if (int'(owner) !== eo) begin fails++; $display("FAIL rot_owner c%0d got %0d want %0d", c, owner, eo); end
        tests++; if (stall !== (3'b111 & ~(3'b001 << eo))) begin fails++; $display("FAIL rot_stall c%0d got %b want %b", c, stall, 3'b111 & ~(3'b001 << eo)); end
        tests++; if (rdata[eo] !== {16'hC0DE, 16'(eo * 16)}) begin fails++; $display("FAIL rot_rdata c%0d got %h want %h", c, rdata[eo], {16'hC0DE, 16'(eo * 16)}); end
      end else begin
        tests++; if (stall !== 3'b111) begin fails++; $display("FAIL rot_idle_stall c%0d got %b want 111", c, stall); end
      end
      tick();
    end
  endtask

  task automatic test_read_only();
    do_reset();
    wen = 3'b010; addr[1] = 9'h004; wdata[1] = 32'hDEADBEEF; strobe[1] = 4'hF;
    tick(); @(negedge clk);
    tests++; if ({owner_valid, owner} !== 3'b101) begin fails++; $display("FAIL ro_owner got %b want 101", {owner_valid, owner}); end
    tests++; if (error[1] !== 1'b1) begin fails++; $display("FAIL ro_error got %b want 1", error[1]); end
    tests++; if (stall[1] !== 1'b0) begin fails++; $display("FAIL ro_stall got %b want 0", stall[1]); end
    tests++; if (cache_wen !== 1'b0) begin fails++; $display("FAIL ro_cache_wen got %b want 0", cache_wen); end
    tick();
    wen = 3'b000; ren = 3'b001; addr[0] = 9'h004;
    tick(); tick(); @(negedge clk);
    tests++; if ({owner_valid, owner} !== 3'b100) begin fails++; $display("FAIL ro_read_owner got %b want 100", {owner_valid, owner}); end
    tests++; if (rdata[0] !== 32'hC0DE0001) begin fails++; $display("FAIL ro_readback got %h want C0DE0001", rdata[0]); end
    tick();
  endtask

  task automatic test_bounds();
    do_reset();
    ren = 3'b100; addr[2] = 9'h180;
    tick(); @(negedge clk);
    tests++; if ({owner_valid, owner} !== 3'b110) begin fails++; $display("FAIL oob_owner got %b want 110", {owner_valid, owner}); end
    tests++; if (error[2] !== 1'b1) begin fails++; $display("FAIL oob_error got %b want 1", error[2]); end
    tests++; if (stall[2] !== 1'b0) begin fails++; $display("FAIL oob_stall got %b want 0", stall[2]); end
    tests++; if (cache_ren !== 1'b0) begin fails++; $display("FAIL oob_cache_ren got %b want 0", cache_ren); end
    tick();
    addr[2] = 9'h17C;
    @(negedge clk);
    tests++; if (error[2] !== 1'b0) begin fails++; $display("FAIL last_word_error got %b want 0", error[2]); end
    tests++; if (cache_ren !== 1'b1 || cache_addr !== 9'h17C) begin fails++; $display("FAIL last_word_cache got %b/%h want 1/17C", cache_ren, cache_addr); end
    tests++; if (rdata[2] !== 32'hC0DE005F) begin fails++; $display("FAIL last_word_rdata got %h want C0DE005F", rdata[2]); end
    tick();
    wen = 3'b100;
    @(negedge clk);
    tests++; if (error[2] !== 1'b1) begin fails++; $display("FAIL rw_both_error got %b want 1", error[2]); end
    tests++; if ({cache_ren, cache_wen} !== 2'b00) begin fails++; $display("FAIL rw_both_cache got %b want 00", {cache_ren, cache_wen}); end
    tick();
  endtask

  task automatic test_stall();
    do_reset();
    ren = 3'b001; addr[0] = 9'h020;
    tick();
    cstall = 1'b1; ren = 3'b011; addr[1] = 9'h030;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++; if (stall[1:0] !== 2'b11) begin fails++; $display("FAIL stall_hold c%0d got %b want 11", c, stall[1:0]); end
      tests++; if ({owner_valid, owner} !== 3'b100) begin fails++; $display("FAIL stall_owner c%0d got %b want 100", c, {owner_valid, owner}); end
      tick();
    end
    cstall = 1'b0;
    @(negedge clk);
    tests++; if (stall[1:0] !== 2'b10) begin fails++; $display("FAIL stall_release got %b want 10", stall[1:0]); end
    tests++; if (rdata[0] !== 32'hC0DE0008) begin fails++; $display("FAIL stall_rdata0 got %h want C0DE0008", rdata[0]); end
    tests++; if (rdata[1] !== BAD) begin fails++; $display("FAIL stall_rdata1 got %h want %h", rdata[1], BAD); end
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    ren = 3'b011; addr[0] = 9'h020; cstall = 1'b1;
    tick(); #2;
    tests++; if (owner_valid !== 1'b1) begin fails++; $display("FAIL mid_pre_valid got %b want 1", owner_valid); end
    n_rst = 1'b0; #1;
    tests++; if (owner_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b want 0", owner_valid); end
    tests++; if ({cache_ren, cache_wen, cache_addr} !== '0) begin fails++; $display("FAIL mid_cache got %h want 0", {cache_ren, cache_wen, cache_addr}); end
    tests++; if (stall !== 3'b011) begin fails++; $display("FAIL mid_stall got %b want 011", stall); end
    @(posedge clk); #1;
    n_rst = 1'b1; cstall = 1'b0;
    tick(); @(negedge clk);
    tests++; if ({owner_valid, owner} !== 3'b100) begin fails++; $display("FAIL mid_regrant got %b want 100", {owner_valid, owner}); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      logic [2:0]  act, e_stall, e_err;
      logic        e_cren, e_cwen, e_ill;
      logic [31:0] e_rd;
      int          o;
      bit          found;
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 3) == 0) begin
          int r;
          r = $urandom_range(0, 9);
          ren[p] = (r < 4);
          wen[p] = (r >= 3 && r < 6);
          addr[p] = ($urandom_range(0, 15) == 0) ? 9'(4*NW + 4*$urandom_range(0, 31))
                                                 : 9'(4*$urandom_range(0, NW-1));
          wdata[p]  = $urandom;
          strobe[p] = 4'($urandom);
        end
      end
      cstall = ($urandom_range(0, 3) == 0);
      cerr   = ($urandom_range(0, 7) == 0);
      @(negedge clk);
      act = ren | wen; e_stall = act; e_err = '0; e_cren = 0; e_cwen = 0; e_ill = 0; o = m_owner;
      if (m_owned && act[o]) begin
        e_ill = (int'(addr[o]) >= 4*NW) || (ren[o] && wen[o]) || (wen[o] && RO[o]);
        if (e_ill) begin
          e_err[o] = 1'b1; e_stall[o] = 1'b0;
        end else begin
          e_cren = ren[o]; e_cwen = wen[o]; e_stall[o] = cstall; e_err[o] = cerr;
        end
      end
      tests++; if (owner_valid !== m_owned) begin fails++; $display("FAIL rnd_valid cyc%0d got %b want %b", cyc, owner_valid, m_owned); end
      if (m_owned) begin
        tests++; if (int'(owner) !== o) begin fails++; $display("FAIL rnd_owner cyc%0d got %0d want %0d", cyc, owner, o); end
      end
      tests++; if (stall !== e_stall) begin fails++; $display("FAIL rnd_stall cyc%0d got %b want %b", cyc, stall, e_stall); end
      tests++; if (error !== e_err) begin fails++; $display("FAIL rnd_error cyc%0d got %b want %b", cyc, error, e_err); end
      tests++; if ({cache_ren, cache_wen} !== {e_cren, e_cwen}) begin fails++; $display("FAIL rnd_cache_en cyc%0d got %b want %b", cyc, {cache_ren, cache_wen}, {e_cren, e_cwen}); end
      if (e_cren || e_cwen) begin
        tests++; if (cache_addr !== addr[o]) begin fails++; $display("FAIL rnd_cache_addr cyc%0d got %h want %h", cyc, cache_addr, addr[o]); end
      end
      if (e_cwen) begin
        tests++; if ({cache_wdata, cache_strobe} !== {wdata[o], strobe[o]}) begin fails++; $display("FAIL rnd_cache_wr cyc%0d got %h want %h", cyc, {cache_wdata, cache_strobe}, {wdata[o], strobe[o]}); end
      end
      for (int p = 0; p < NP; p++) begin
        if (!(m_owned && p == o && e_ill)) begin
          e_rd = BAD;
          if (m_owned && p == o && act[o]) e_rd = e_cren ? mem[addr[o][8:2]] : 32'h0;
          tests++; if (rdata[p] !== e_rd) begin fails++; $display("FAIL rnd_rdata cyc%0d port%0d got %h want %h", cyc, p, rdata[p], e_rd); end
        end
      end
      // Advance the model to the next cycle.
      if (!m_owned) begin
        found = 0;
        for (int k = 1; k <= NP; k++) begin
          if (!found && act[(m_last + k) % NP]) begin
            found = 1; m_owner = (m_last + k) % NP;
          end
        end
        if (found) begin
          m_owned = 1; m_last = m_owner; m_cnt = 0;
        end
      end else if (!act[o]) begin
        m_owned = 0;
      end else if (e_ill || !cstall) begin
        m_cnt++;
        if (m_cnt >= MB && (act & ~(3'b001 << o)) != 3'b000) m_owned = 0;
      end
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst = 1'b0; ren = '0; wen = '0; addr = '0; wdata = '0; strobe = '0;
    cstall = 1'b0; cerr = 1'b0;
    test_reset();
    test_first_read();
    test_rotation();
    test_read_only();
    test_bounds();
    test_stall();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
